enemy_shooter_sprite_fetch: RTL and testbench

Per-pixel sprite fetch stage for the enemy shooter, directly upstream of the enemy shooter colour palette. It latches the enemy's position and alive status once per video frame. For each DrawX/DrawY it tests the pixel against the sprite box, drives the sprite ROM address, and outputs a 4-bit palette index plus an opaque flag. It also sequences a two-frame walk animation and a red hit-flash.

---
 rtl/enemy_shooter_sprite_fetch.sv | 135 +++++++++++++
 tb/tb_enemy_shooter_sprite_fetch.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_shooter_sprite_fetch.sv
// rtl/enemy_shooter_sprite_fetch.sv - per-pixel enemy sprite fetch with walk animation and hit flash
module enemy_shooter_sprite_fetch #(
  parameter int SPRITE_W     = 32,
  parameter int SPRITE_H     = 32,
  parameter int ANIM_FRAMES  = 2,
  parameter int ANIM_PERIOD  = 16,
  parameter int FLASH_FRAMES = 8,
  parameter int ADDR_W       = $clog2(ANIM_FRAMES * SPRITE_W * SPRITE_H)
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_start,
  input  logic [9:0]        enemy_x,
  input  logic [9:0]        enemy_y,
  input  logic              enemy_alive,
  input  logic              hit,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3:0]        rom_data,
  output logic [3:0]        palette_idx,
  output logic              sprite_on
);

  localparam int XW  = $clog2(SPRITE_W);
  localparam int YW  = $clog2(SPRITE_H);
  localparam int AFW = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
  localparam int ATW = (ANIM_PERIOD > 1) ? $clog2(ANIM_PERIOD) : 1;
  localparam int FW  = $clog2(FLASH_FRAMES + 1);

  typedef enum logic [1:0] {HIDDEN, ALIVE, FLASH} state_t;

  state_t           state_q, state_d;
  logic [FW-1:0]    flash_cnt_q, flash_cnt_d;
  logic [ATW-1:0]   anim_tick_q, anim_tick_d;
  logic [AFW-1:0]   anim_frame_q, anim_frame_d;
  logic [9:0]       x_lat_q, x_lat_d, y_lat_q, y_lat_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic             vis1_q, vis1_d, red1_q, red1_d;
  logic             vis2_q, red2_q;
  logic [3:0]       palette_idx_q, palette_idx_d;
  logic             sprite_on_q, sprite_on_d;
  logic             in_box;
  logic [XW-1:0]    dx;
  logic [YW-1:0]    dy;

  // Frame-rate control: hit overrides frame_start, but a departing enemy always hides.
  always_comb begin
    state_d      = state_q;
    flash_cnt_d  = flash_cnt_q;
    anim_tick_d  = anim_tick_q;
    anim_frame_d = anim_frame_q;
    x_lat_d      = x_lat_q;
    y_lat_d      = y_lat_q;
    if (frame_start) begin
      x_lat_d = enemy_x;
      y_lat_d = enemy_y;
      if (state_q != HIDDEN) begin
        if (anim_tick_q == ATW'(ANIM_PERIOD - 1)) begin
          anim_tick_d  = '0;
          anim_frame_d = (anim_frame_q == AFW'(ANIM_FRAMES - 1)) ? '0 : anim_frame_q + 1'b1;
        end else begin
          anim_tick_d = anim_tick_q + 1'b1;
        end
      end
      if (state_q == FLASH) begin
        flash_cnt_d = flash_cnt_q - 1'b1;
        if (flash_cnt_q == FW'(1)) state_d = ALIVE;
      end
      if (state_q == HIDDEN && enemy_alive) state_d = ALIVE;
    end
    if (hit && state_q != HIDDEN) begin
      state_d     = FLASH;
      flash_cnt_d = FW'(FLASH_FRAMES);
    end
    if (frame_start && !enemy_alive) begin
      state_d      = HIDDEN;
      flash_cnt_d  = '0;
      anim_tick_d  = '0;
      anim_frame_d = '0;
    end
  end

  // Pixel pipeline; latched positions at or beyond the visible area never draw.
  always_comb begin
    in_box = (x_lat_q < 10'd640) && (y_lat_q < 10'd480) &&
             (DrawX >= x_lat_q) && ({1'b0, DrawX} < ({1'b0, x_lat_q} + 11'(SPRITE_W))) &&
             (DrawY >= y_lat_q) && ({1'b0, DrawY} < ({1'b0, y_lat_q} + 11'(SPRITE_H)));
    dx = XW'(DrawX - x_lat_q);
    dy = YW'(DrawY - y_lat_q);
    rom_addr_d = in_box ? (ADDR_W'(anim_frame_q) * ADDR_W'(SPRITE_W * SPRITE_H) +
                           ADDR_W'(dy) * ADDR_W'(SPRITE_W) + ADDR_W'(dx)) : '0;
    vis1_d = in_box && (state_q != HIDDEN);
    red1_d = (state_q == FLASH) && flash_cnt_q[0];
    sprite_on_d   = vis2_q && (rom_data != 4'h0);
    palette_idx_d = !sprite_on_d ? 4'h0 : (red2_q ? 4'h3 : rom_data);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q       <= HIDDEN;
      flash_cnt_q   <= '0;
      anim_tick_q   <= '0;
      anim_frame_q  <= '0;
      x_lat_q       <= '0;
      y_lat_q       <= '0;
      rom_addr_q    <= '0;
      vis1_q        <= 1'b0;
      red1_q        <= 1'b0;
      vis2_q        <= 1'b0;
      red2_q        <= 1'b0;
      palette_idx_q <= 4'h0;
      sprite_on_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      flash_cnt_q   <= flash_cnt_d;
      anim_tick_q   <= anim_tick_d;
      anim_frame_q  <= anim_frame_d;
      x_lat_q       <= x_lat_d;
      y_lat_q       <= y_lat_d;
      rom_addr_q    <= rom_addr_d;
      vis1_q        <= vis1_d;
      red1_q        <= red1_d;
      vis2_q        <= vis1_q;
      red2_q        <= red1_q;
      palette_idx_q <= palette_idx_d;
      sprite_on_q   <= sprite_on_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign palette_idx = palette_idx_q;
  assign sprite_on   = sprite_on_q;

endmodule

// File: tb/tb_enemy_shooter_sprite_fetch.sv
// tb/tb_enemy_shooter_sprite_fetch.sv - directed scoreboard bench for enemy_shooter_sprite_fetch
module tb_enemy_shooter_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        frame_start;
  logic [9:0]  enemy_x, enemy_y;
  logic        enemy_alive;
  logic        hit;
  logic [9:0]  DrawX, DrawY;
  logic [10:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  palette_idx;
  logic        sprite_on;

  enemy_shooter_sprite_fetch dut (
    .Clk(Clk), .Reset(Reset), .frame_start(frame_start),
    .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_alive(enemy_alive), .hit(hit),
    .DrawX(DrawX), .DrawY(DrawY), .rom_addr(rom_addr), .rom_data(rom_data),
    .palette_idx(palette_idx), .sprite_on(sprite_on)
  );

  always #5 Clk = ~Clk;

  // Registered-read sprite ROM
  logic [3:0] mem [0:2047];
  always @(posedge Clk) rom_data <= mem[rom_addr];

  typedef struct packed {
    logic       on;
    logic [3:0] idx;
  } exp_t;

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;
  logic drv = 1'b0;
  logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge Clk);
    #1;
    v3 = v2;
    v2 = v1;
    v1 = drv;
    if (v3) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sprite_on", 32'(sprite_on), 32'(e.on));
        chk("palette_idx", 32'(palette_idx), 32'(e.idx));
      end
    end
  endtask

  task automatic pixel(input int x, input int y, input int exp_addr,
                       input logic exp_on, input logic [3:0] exp_idx);
    exp_t e;
    DrawX = 10'(x);
    DrawY = 10'(y);
    drv = 1'b1;
    e.on = exp_on;
    e.idx = exp_idx;
    sb_q.push_back(e);
    tick();
    drv = 1'b0;
    if (exp_addr >= 0) chk("rom_addr", 32'(rom_addr), 32'(exp_addr));
  endtask

  task automatic flush();
    repeat (3) tick();
  endtask

  task automatic frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic do_hit();
    hit = 1'b1;
    tick();
    hit = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = (a < 1024) ? 4'h5 : 4'h7;
    mem[31] = 4'h9;
    mem[33] = 4'h0;
    Reset = 1'b1; frame_start = 1'b0; hit = 1'b0; enemy_alive = 1'b0;
    enemy_x = 10'd0; enemy_y = 10'd0; DrawX = 10'd0; DrawY = 10'd0;
    repeat (3) tick();
    chk("reset_rom_addr", 32'(rom_addr), 32'd0);
    chk("reset_sprite_on", 32'(sprite_on), 32'd0);
    chk("reset_palette", 32'(palette_idx), 32'd0);
    Reset = 1'b0;

    // hidden after reset: in box of (0,0) but invisible
    pixel(0, 0, 0, 1'b0, 4'h0);
    flush();

    enemy_alive = 1'b1; enemy_x = 10'd100; enemy_y = 10'd50;
    frame();
    pixel(100, 50, 0, 1'b1, 4'h5);
    pixel(131, 50, 31, 1'b1, 4'h9);
    pixel(132, 50, 0, 1'b0, 4'h0);
    pixel(99, 50, 0, 1'b0, 4'h0);
    pixel(101, 51, 33, 1'b0, 4'h0);
    pixel(131, 81, 1023, 1'b1, 4'h5);
    pixel(100, 82, 0, 1'b0, 4'h0);
    flush();

    // mid-frame move takes effect only at next frame_start
    enemy_x = 10'd200;
    tick();
    pixel(100, 50, 0, 1'b1, 4'h5);
    pixel(200, 50, 0, 1'b0, 4'h0);
    flush();
    frame();
    pixel(200, 50, 0, 1'b1, 4'h5);
    pixel(100, 50, 0, 1'b0, 4'h0);
    flush();

    enemy_x = 10'd620;
    frame();
    pixel(620, 50, 0, 1'b1, 4'h5);
    pixel(639, 50, 19, 1'b1, 4'h5);
    pixel(0, 50, 0, 1'b0, 4'h0);
    pixel(11, 50, 0, 1'b0, 4'h0);
    flush();

    // animation: 16 counted frame_starts advance one step
    enemy_x = 10'd100;
    frame();
    for (int i = 3; i < 15; i++) frame();
    pixel(100, 50, 0, 1'b1, 4'h5);
    flush();
    frame();
    pixel(100, 50, 1024, 1'b1, 4'h7);
    pixel(101, 51, 1057, 1'b1, 4'h7);
    flush();
    repeat (16) frame();
    pixel(100, 50, 0, 1'b1, 4'h5);
    flush();

    // hit flash sequence
    do_hit();
    pixel(100, 50, 0, 1'b1, 4'h5);
    flush();
    for (int i = 1; i <= 8; i++) begin
      frame();
      pixel(100, 50, 0, 1'b1, (i % 2 == 1) ? 4'h3 : 4'h5);
      if (i == 1) pixel(101, 51, 33, 1'b0, 4'h0);
      flush();
    end

    // hit coincident with frame_start reloads without decrement
    do_hit();
    repeat (6) frame();
    pixel(100, 50, 0, 1'b1, 4'h5);
    flush();
    hit = 1'b1; frame_start = 1'b1;
    tick();
    hit = 1'b0; frame_start = 1'b0;
    pixel(100, 50, 0, 1'b1, 4'h5);
    flush();
    frame();
    pixel(100, 50, 1024, 1'b1, 4'h3);
    flush();

    // enemy leaves: hidden all frame, animation cleared
    enemy_alive = 1'b0;
    frame();
    pixel(100, 50, 0, 1'b0, 4'h0);
    pixel(101, 51, 33, 1'b0, 4'h0);
    flush();
    enemy_alive = 1'b1;
    frame();
    pixel(100, 50, 0, 1'b1, 4'h5);
    flush();

    // hit while hidden is ignored
    enemy_alive = 1'b0;
    frame();
    do_hit();
    enemy_alive = 1'b1;
    frame();
    pixel(100, 50, 0, 1'b1, 4'h5);
    flush();
    frame();
    pixel(100, 50, 0, 1'b1, 4'h5);
    flush();

    // reset mid-frame
    Reset = 1'b1;
    tick();
    chk("midreset_sprite_on", 32'(sprite_on), 32'd0);
    chk("midreset_palette", 32'(palette_idx), 32'd0);
    chk("midreset_rom_addr", 32'(rom_addr), 32'd0);
    Reset = 1'b0;
    pixel(100, 50, 0, 1'b0, 4'h0);
    pixel(5, 5, 165, 1'b0, 4'h0);
    flush();
    frame();
    pixel(100, 50, 0, 1'b1, 4'h5);
    flush();

    // off-screen position and bottom clipping
    enemy_x = 10'd700;
    frame();
    pixel(700, 50, -1, 1'b0, 4'h0);
    flush();
    enemy_x = 10'd100; enemy_y = 10'd470;
    frame();
    pixel(100, 479, 288, 1'b1, 4'h5);
    flush();

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
